// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: symbol codes, state enum and unit counts.
package morse_pkg;

  localparam logic [5:0] SYM_0 = 6'd0,  SYM_1 = 6'd1,  SYM_2 = 6'd2,  SYM_3 = 6'd3;
  localparam logic [5:0] SYM_4 = 6'd4,  SYM_5 = 6'd5,  SYM_6 = 6'd6,  SYM_7 = 6'd7;
  localparam logic [5:0] SYM_8 = 6'd8,  SYM_9 = 6'd9;
  localparam logic [5:0] SYM_A = 6'd10, SYM_B = 6'd11, SYM_C = 6'd12, SYM_D = 6'd13;
  localparam logic [5:0] SYM_E = 6'd14, SYM_F = 6'd15, SYM_G = 6'd16, SYM_H = 6'd17;
  localparam logic [5:0] SYM_I = 6'd18, SYM_J = 6'd19, SYM_K = 6'd20, SYM_L = 6'd21;
  localparam logic [5:0] SYM_M = 6'd22, SYM_N = 6'd23, SYM_O = 6'd24, SYM_P = 6'd25;
  localparam logic [5:0] SYM_Q = 6'd26, SYM_R = 6'd27, SYM_S = 6'd28, SYM_T = 6'd29;
  localparam logic [5:0] SYM_U = 6'd30, SYM_V = 6'd31, SYM_W = 6'd32, SYM_X = 6'd33;
  localparam logic [5:0] SYM_Y = 6'd34, SYM_Z = 6'd35;

  localparam logic [5:0] SYM_DECODING = 6'd36;
  localparam logic [5:0] SYM_WORD     = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARK    = 2'd1,
    ST_ELEMGAP = 2'd2,
    ST_CHARGAP = 2'd3
  } enc_state_t;

  localparam logic [2:0] DOT_U  = 3'd1;
  localparam logic [2:0] DASH_U = 3'd3;
  localparam logic [2:0] ELEM_U = 3'd1;
  localparam logic [2:0] CHAR_U = 3'd3;
  localparam logic [2:0] WORD_U = 3'd7;

  // Element idx of a pattern stored MSB-first in the low len bits (1 = dash).
  function automatic logic elem_bit(input logic [4:0] pat, input logic [2:0] len,
                                    input logic [2:0] idx);
    logic [2:0] pos;
    pos = 3'(len - 3'd1 - idx);
    return pat[pos];
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational code-to-Morse lookup: code -> {valid, len, pat}, pattern MSB-first, 1 = dash.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] i_code,
  output logic       o_valid,
  output logic [2:0] o_len,
  output logic [4:0] o_pat
);

  logic [7:0] w_ent;

  always_comb begin
    o_valid = 1'b1;
    w_ent   = 8'd0;
    case (i_code)
      SYM_0: w_ent = {3'd5, 5'b11111};
      SYM_1: w_ent = {3'd5, 5'b01111};
      SYM_2: w_ent = {3'd5, 5'b00111};
      SYM_3: w_ent = {3'd5, 5'b00011};
      SYM_4: w_ent = {3'd5, 5'b00001};
      SYM_5: w_ent = {3'd5, 5'b00000};
      SYM_6: w_ent = {3'd5, 5'b10000};
      SYM_7: w_ent = {3'd5, 5'b11000};
      SYM_8: w_ent = {3'd5, 5'b11100};
      SYM_9: w_ent = {3'd5, 5'b11110};
      SYM_A: w_ent = {3'd2, 5'b00001};
      SYM_B: w_ent = {3'd4, 5'b01000};
      SYM_C: w_ent = {3'd4, 5'b01010};
      SYM_D: w_ent = {3'd3, 5'b00100};
      SYM_E: w_ent = {3'd1, 5'b00000};
      SYM_F: w_ent = {3'd4, 5'b00010};
      SYM_G: w_ent = {3'd3, 5'b00110};
      SYM_H: w_ent = {3'd4, 5'b00000};
      SYM_I: w_ent = {3'd2, 5'b00000};
      SYM_J: w_ent = {3'd4, 5'b00111};
      SYM_K: w_ent = {3'd3, 5'b00101};
      SYM_L: w_ent = {3'd4, 5'b00100};
      SYM_M: w_ent = {3'd2, 5'b00011};
      SYM_N: w_ent = {3'd2, 5'b00010};
      SYM_O: w_ent = {3'd3, 5'b00111};
      SYM_P: w_ent = {3'd4, 5'b00110};
      SYM_Q: w_ent = {3'd4, 5'b01101};
      SYM_R: w_ent = {3'd3, 5'b00010};
      SYM_S: w_ent = {3'd3, 5'b00000};
      SYM_T: w_ent = {3'd1, 5'b00001};
      SYM_U: w_ent = {3'd3, 5'b00001};
      SYM_V: w_ent = {3'd4, 5'b00001};
      SYM_W: w_ent = {3'd3, 5'b00011};
      SYM_X: w_ent = {3'd4, 5'b01001};
      SYM_Y: w_ent = {3'd4, 5'b01011};
      SYM_Z: w_ent = {3'd4, 5'b01100};
      default: o_valid = 1'b0;
    endcase
  end

  assign o_len = w_ent[7:5];
  assign o_pat = w_ent[4:0];

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: one symbol per handshake, keyed line plus dot/dash strobes.
// Optional word space on code 63 when MORSE_ENC_WORD_GAP_EN is defined.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] i_sym,
  input  logic       i_sym_valid,
  output logic       o_sym_ready,
  output logic       o_key,
  output logic       o_dot,
  output logic       o_dash,
  output logic       o_busy,
  output logic       o_err
);

`ifdef MORSE_ENC_WORD_GAP_EN
  localparam int CNT_W = $clog2(7 * UNIT_CYCLES);
`else
  localparam int CNT_W = $clog2(3 * UNIT_CYCLES);
`endif

  function automatic logic [CNT_W-1:0] reload(input logic [2:0] units);
    return CNT_W'(int'(units) * UNIT_CYCLES - 1);
  endfunction

  enc_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx, r_len;
  logic [4:0]       r_pat;
  logic             r_key, r_dot, r_dash, r_err, r_busy;

  logic       w_rom_valid;
  logic [2:0] w_rom_len;
  logic [4:0] w_rom_pat;
  logic       w_load, w_accept, w_err_nxt, w_idx_inc, w_mark_dash, w_mark_entry;
  logic [2:0] w_units;

  morse_rom u_rom (
    .i_code  (i_sym),
    .o_valid (w_rom_valid),
    .o_len   (w_rom_len),
    .o_pat   (w_rom_pat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_units     = DOT_U;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    w_idx_inc   = 1'b0;
    w_mark_dash = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sym_valid) begin
          w_accept = 1'b1;
          if (w_rom_valid) begin
            w_mark_dash = elem_bit(w_rom_pat, w_rom_len, 3'd0);
            w_state_nxt = ST_MARK;
            w_load      = 1'b1;
            w_units     = w_mark_dash ? DASH_U : DOT_U;
          end
`ifdef MORSE_ENC_WORD_GAP_EN
          else if (i_sym == SYM_WORD) begin
            w_state_nxt = ST_CHARGAP;
            w_load      = 1'b1;
            w_units     = WORD_U;
          end
`endif
          else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (r_cnt == '0) begin
          w_idx_inc = 1'b1;
          w_load    = 1'b1;
          if (r_idx == r_len - 3'd1) begin
            w_state_nxt = ST_CHARGAP;
            w_units     = CHAR_U;
          end else begin
            w_state_nxt = ST_ELEMGAP;
            w_units     = ELEM_U;
          end
        end
      end
      ST_ELEMGAP: begin
        if (r_cnt == '0) begin
          // r_idx already points at the next element after the MARK exit.
          w_mark_dash = elem_bit(r_pat, r_len, r_idx);
          w_state_nxt = ST_MARK;
          w_load      = 1'b1;
          w_units     = w_mark_dash ? DASH_U : DOT_U;
        end
      end
      ST_CHARGAP: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mark_entry = w_load && (w_state_nxt == ST_MARK);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_key   <= 1'b0;
      r_dot   <= 1'b0;
      r_dash  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= (w_state_nxt == ST_MARK);
      r_dot   <= w_mark_entry & ~w_mark_dash;
      r_dash  <= w_mark_entry & w_mark_dash;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge Clock) begin
    if (w_load) r_cnt <= reload(w_units);
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    if (w_accept) begin
      r_len <= w_rom_len;
      r_pat <= w_rom_pat;
      r_idx <= 3'd0;
    end else if (w_idx_inc) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  assign o_sym_ready = (r_state == ST_IDLE);
  assign o_key       = r_key;
  assign o_dot       = r_dot;
  assign o_dash      = r_dash;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed table, reset/back-to-back sequences, random symbols vs a string-based model.
module tb_morse_encoder;

  localparam int UC = 2;
`ifdef MORSE_ENC_WORD_GAP_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] i_sym;
  logic       i_sym_valid;
  logic       o_sym_ready, o_key, o_dot, o_dash, o_busy, o_err;

  int checks = 0;
  int errors = 0;

  string MORSE [36] = '{
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--.."
  };

  morse_encoder #(.UNIT_CYCLES(UC)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_sym       (i_sym),
    .i_sym_valid (i_sym_valid),
    .o_sym_ready (o_sym_ready),
    .o_key       (o_key),
    .o_dot       (o_dot),
    .o_dash      (o_dash),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {o_key, o_dot, o_dash, o_busy, o_err, o_sym_ready};
  endfunction

  // Send one code and compare every cycle against a waveform built from the Morse string.
  // Vector bits: {key, dot, dash, busy, err, ready}.
  task automatic run_sym(input logic [5:0] code, input bit noise,
                         output int busy_n, output int err_n, output int dot_n,
                         output int dash_n, output string seen);
    logic [5:0] q[$];
    logic [5:0] act;
    string s;
    int m;
    if (code < 6'd36) begin
      s = MORSE[code];
      for (int i = 0; i < s.len(); i++) begin
        m = (s[i] == "-") ? 3 : 1;
        for (int u = 0; u < m * UC; u++)
          q.push_back({1'b1, u == 0 && s[i] == ".", u == 0 && s[i] == "-", 3'b100});
        for (int u = 0; u < ((i == s.len() - 1) ? 3 : 1) * UC; u++)
          q.push_back(6'b000100);
      end
    end else if (WORD_EN && code == 6'd63) begin
      for (int u = 0; u < 7 * UC; u++) q.push_back(6'b000100);
    end else begin
      q.push_back(6'b000011);
    end
    q.push_back(6'b000001);

    busy_n = 0; err_n = 0; dot_n = 0; dash_n = 0; seen = "";
    i_sym = code;
    i_sym_valid = 1'b1;
    @(posedge Clock); #1;
    i_sym_valid = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      act = outs();
      chk($sformatf("wave code=%0d cyc=%0d", code, j), 32'(act), 32'(q[j]));
      busy_n += int'(act[2]);
      err_n  += int'(act[1]);
      dot_n  += int'(act[4]);
      dash_n += int'(act[3]);
      if (act[4]) seen = {seen, "."};
      if (act[3]) seen = {seen, "-"};
      if (j < q.size() - 1) begin
        if (noise && j + 2 < q.size() && q[j][2]) begin
          i_sym_valid = 1'($urandom_range(0, 1));
          i_sym = 6'($urandom);
        end else begin
          i_sym_valid = 1'b0;
        end
        @(posedge Clock); #1;
      end
    end
    i_sym_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0] code;
    int         busy_cyc;
    int         err_cnt;
    int         n_dot;
    int         n_dash;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b, e, d, h, found;
    string seen;

    vecs[0] = '{6'd14, 8,  0, 1, 0};   // E
    vecs[1] = '{6'd10, 16, 0, 1, 1};   // A
    vecs[2] = '{6'd0,  44, 0, 0, 5};   // 0
    vecs[3] = '{6'd29, 12, 0, 0, 1};   // T
    vecs[4] = '{6'd28, 16, 0, 3, 0};   // S
    vecs[5] = '{6'd40, 0,  1, 0, 0};
    vecs[6] = WORD_EN ? '{6'd63, 14, 0, 0, 0} : '{6'd63, 0, 1, 0, 0};

    Reset = 1'b1;
    i_sym = 6'd0;
    i_sym_valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(6'b000001));
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("post_reset_outputs", 32'(outs()), 32'(6'b000001));

    for (int v = 0; v < 7; v++) begin
      run_sym(vecs[v].code, 1'b0, b, e, d, h, seen);
      chk($sformatf("busy_len code=%0d", vecs[v].code), b, vecs[v].busy_cyc);
      chk($sformatf("err_cnt code=%0d", vecs[v].code), e, vecs[v].err_cnt);
      chk($sformatf("dots code=%0d", vecs[v].code), d, vecs[v].n_dot);
      chk($sformatf("dashes code=%0d", vecs[v].code), h, vecs[v].n_dash);
    end

    // Back-to-back unencodable codes: err on consecutive cycles, ready never drops.
    i_sym = 6'd40; i_sym_valid = 1'b1;
    @(posedge Clock); #1;
    chk("b2b_err_first", 32'(outs()), 32'(6'b000011));
    i_sym = 6'd50;
    @(posedge Clock); #1;
    chk("b2b_err_second", 32'(outs()), 32'(6'b000011));
    i_sym_valid = 1'b0;
    @(posedge Clock); #1;
    chk("b2b_err_clear", 32'(outs()), 32'(6'b000001));

    // Reset in the middle of the dash of T drops the symbol.
    i_sym = 6'd29; i_sym_valid = 1'b1;
    @(posedge Clock); #1;
    i_sym_valid = 1'b0;
    chk("t_dash_start", 32'(outs()), 32'(6'b101100));
    repeat (2) @(posedge Clock);
    #1;
    chk("t_mid_dash", 32'(outs()), 32'(6'b100100));
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("mid_reset", 32'(outs()), 32'(6'b000001));
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("mid_reset_idle", 32'(outs()), 32'(6'b000001));
    run_sym(6'd14, 1'b0, b, e, d, h, seen);
    chk("e_after_reset_busy", b, 8);

    // Every encodable code: strobe sequence must decode back to the same code.
    for (int c = 0; c < 36; c++) begin
      run_sym(6'(c), 1'b1, b, e, d, h, seen);
      found = -1;
      for (int k = 0; k < 36; k++) if (MORSE[k] == seen) found = k;
      chk($sformatf("loopback code=%0d", c), found, c);
    end

    // Random codes with noise on i_sym/i_sym_valid while busy.
    for (int r = 0; r < 40; r++) begin
      run_sym(6'($urandom_range(0, 63)), 1'b1, b, e, d, h, seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
